// File: rtl/fetch_queue.sv
// fetch_queue: decoupling FIFO between fetch and decode.
// Holds {pc, pc+4, inst, prediction, trap packet} per entry and presents the
// oldest entry to decode. A fetch-side trap locks further enqueues until the
// redirect flush that the trap will eventually cause.

package fetch_queue_pkg;
  typedef logic [31:0] inst_t;

  typedef struct packed {
    logic        valid;
    logic [3:0]  cause;
    logic [31:0] tval;
  } trap_req_t;

  localparam logic [3:0] CAUSE_INST_MISALIGNED    = 4'd0;
  localparam logic [3:0] CAUSE_INST_ACCESS_FAULT  = 4'd1;
  localparam logic [3:0] CAUSE_ILLEGAL_INST       = 4'd2;
endpackage

module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             start,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [31:0]      pc_f,
  input  logic [31:0]      pcplus4_f,
  input  inst_t            inst_f,
  input  logic             pred_taken_f,
  input  trap_req_t        trap_req_f,
  input  logic             flush,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [31:0]      pc_d,
  output logic [31:0]      pcplus4_d,
  output inst_t            inst_d,
  output logic             pred_taken_d,
  output trap_req_t        trap_req_d,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pcplus4;
    inst_t       inst;
    logic        pred_taken;
    trap_req_t   trap_req;
  } entry_t;

  entry_t           entry_mem [DEPTH];
  entry_t           head_entry;

  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             trap_lock_reg, trap_lock_next;
  logic             do_enq, do_deq;

  // Handshake decode: both ready/valid come only from registered state.
  always_comb begin
    enq_ready = start & ~trap_lock_reg & (count_reg != FULL_CNT);
    deq_valid = (count_reg != '0);
    do_enq    = enq_valid & enq_ready & ~flush;
    do_deq    = deq_valid & deq_ready & ~flush;
  end

  // Next-state for pointers, occupancy and trap lock; flush overrides all.
  always_comb begin
    head_next      = head_reg;
    tail_next      = tail_reg;
    count_next     = count_reg;
    trap_lock_next = trap_lock_reg;
    if (flush) begin
      head_next      = '0;
      tail_next      = '0;
      count_next     = '0;
      trap_lock_next = 1'b0;
    end else begin
      if (do_enq) tail_next = tail_reg + PTR_W'(1);
      if (do_deq) head_next = head_reg + PTR_W'(1);
      case ({do_enq, do_deq})
        2'b10:   count_next = count_reg + CNT_W'(1);
        2'b01:   count_next = count_reg - CNT_W'(1);
        default: count_next = count_reg;
      endcase
      if (do_enq && trap_req_f.valid) trap_lock_next = 1'b1;
    end
  end

  // Control state register; start low empties the queue immediately.
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      head_reg      <= '0;
      tail_reg      <= '0;
      count_reg     <= '0;
      trap_lock_reg <= 1'b0;
    end else begin
      head_reg      <= head_next;
      tail_reg      <= tail_next;
      count_reg     <= count_next;
      trap_lock_reg <= trap_lock_next;
    end
  end

  // Entry storage: written at tail on enqueue, never cleared.
  always_ff @(posedge clk) begin
    if (do_enq) begin
      entry_mem[tail_reg] <= '{pc:         pc_f,
                               pcplus4:    pcplus4_f,
                               inst:       inst_f,
                               pred_taken: pred_taken_f,
                               trap_req:   trap_req_f};
    end
  end

  // Head read is combinational (no bypass); outputs read zero when empty.
  always_comb begin
    head_entry = deq_valid ? entry_mem[head_reg] : '0;
    pc_d         = head_entry.pc;
    pcplus4_d    = head_entry.pcplus4;
    inst_d       = head_entry.inst;
    pred_taken_d = head_entry.pred_taken;
    trap_req_d   = head_entry.trap_req;
    count        = count_reg;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based reference model.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk;
  logic             start;
  logic             enq_valid;
  logic             enq_ready;
  logic [31:0]      pc_f;
  logic [31:0]      pcplus4_f;
  inst_t            inst_f;
  logic             pred_taken_f;
  trap_req_t        trap_req_f;
  logic             flush;
  logic             deq_valid;
  logic             deq_ready;
  logic [31:0]      pc_d;
  logic [31:0]      pcplus4_d;
  inst_t            inst_d;
  logic             pred_taken_d;
  trap_req_t        trap_req_d;
  logic [CNT_W-1:0] count;

  fetch_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .start(start),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .pc_f(pc_f), .pcplus4_f(pcplus4_f), .inst_f(inst_f),
    .pred_taken_f(pred_taken_f), .trap_req_f(trap_req_f),
    .flush(flush),
    .deq_valid(deq_valid), .deq_ready(deq_ready),
    .pc_d(pc_d), .pcplus4_d(pcplus4_d), .inst_d(inst_d),
    .pred_taken_d(pred_taken_d), .trap_req_d(trap_req_d),
    .count(count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic [31:0] inst;
    logic        pred;
    trap_req_t   trap;
  } model_entry_t;

  model_entry_t m_q[$];
  bit           m_lock;
  int           n_tests;
  int           n_fail;
  int           cyc;

  // One comparison: count it, report a mismatch.
  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic drive(bit v, logic [31:0] pc, logic [31:0] inst, bit pred,
                       bit tv, logic [3:0] cause, logic [31:0] tval,
                       bit fl, bit dr);
    enq_valid    = v;
    pc_f         = pc;
    pcplus4_f    = pc + 32'd4;
    inst_f       = inst;
    pred_taken_f = pred;
    trap_req_f   = '{valid: tv, cause: cause, tval: tval};
    flush        = fl;
    deq_ready    = dr;
  endtask

  // Check all outputs against the model, then advance one clock and the model.
  task automatic cycle();
    bit           m_rdy, e, d;
    model_entry_t hd;
    #3;
    m_rdy = start && !m_lock && (m_q.size() < DEPTH);
    if (m_q.size() > 0) hd = m_q[0];
    else hd = '{pc: 32'h0, pcplus4: 32'h0, inst: 32'h0, pred: 1'b0, trap: '0};
    check_eq("enq_ready", 64'(enq_ready), 64'(m_rdy));
    check_eq("deq_valid", 64'(deq_valid), 64'(m_q.size() > 0));
    check_eq("count", 64'(count), 64'(m_q.size()));
    check_eq("pc_d", 64'(pc_d), 64'(hd.pc));
    check_eq("pcplus4_d", 64'(pcplus4_d), 64'(hd.pcplus4));
    check_eq("inst_d", 64'(inst_d), 64'(hd.inst));
    check_eq("pred_taken_d", 64'(pred_taken_d), 64'(hd.pred));
    check_eq("trap_req_d", 64'(trap_req_d), 64'(hd.trap));
    e = enq_valid && m_rdy && !flush;
    d = (m_q.size() > 0) && deq_ready && !flush;
    $display("[TB] cyc=%0d enq=%0b deq=%0b flush=%0b pc_f=0x%0h pc_d=0x%0h count=%0d",
             cyc, e, d, flush, pc_f, pc_d, count);
    @(posedge clk);
    if (!start || flush) begin
      m_q.delete();
      m_lock = 1'b0;
    end else begin
      if (d) void'(m_q.pop_front());
      if (e) begin
        m_q.push_back('{pc: pc_f, pcplus4: pcplus4_f, inst: inst_f,
                        pred: pred_taken_f, trap: trap_req_f});
        if (trap_req_f.valid) m_lock = 1'b1;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle(bit fl, bit dr);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, fl, dr);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    m_lock  = 1'b0;
    start   = 1'b0;
    idle(1'b0, 1'b0);

    // Reset state
    cycle();
    cycle();
    start = 1'b1;

    // Fill without dequeue, 5th enqueue rejected
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'(i * 4), 32'h00000013 + 32'(i), i[0], 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
      cycle();
    end
    check_eq("fill_head_pc", 64'(pc_d), 64'h0);
    check_eq("fill_head_pc4", 64'(pcplus4_d), 64'h4);
    idle(1'b1, 1'b0);
    cycle();

    // Streaming across pointer wrap
    for (int i = 0; i < 17; i++) begin
      drive(i < 16, 32'h100 + 32'(i * 4), $urandom, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1);
      cycle();
    end
    idle(1'b0, 1'b1);
    cycle();

    // Flush with simultaneous enqueue and dequeue
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h300 + 32'(i * 4), $urandom, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
      cycle();
    end
    drive(1'b1, 32'h3F0, $urandom, 1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b1);
    cycle();
    idle(1'b0, 1'b0);
    cycle();

    // Trap lock
    drive(1'b1, 32'h2, 32'hDEAD0013, 1'b0, 1'b1, CAUSE_INST_MISALIGNED, 32'h2, 1'b0, 1'b0);
    cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h6 + 32'(i * 4), $urandom, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, i == 2);
      cycle();
    end
    idle(1'b1, 1'b0);
    cycle();
    idle(1'b0, 1'b0);
    cycle();

    // Decode stall stability
    drive(1'b1, 32'h40, 32'h00000013, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
    cycle();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h44 + 32'(i * 4), $urandom, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
      cycle();
    end
    check_eq("stall_pc_d", 64'(pc_d), 64'h40);
    check_eq("stall_inst_d", 64'(inst_d), 64'h13);
    idle(1'b1, 1'b0);
    cycle();

    // Async reset mid-stream with two entries queued
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h500 + 32'(i * 4), $urandom, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
      cycle();
    end
    idle(1'b0, 1'b0);
    #2;
    start = 1'b0;
    #1;
    check_eq("areset_deq_valid", 64'(deq_valid), 64'h0);
    check_eq("areset_count", 64'(count), 64'h0);
    check_eq("areset_enq_ready", 64'(enq_ready), 64'h0);
    m_q.delete();
    m_lock = 1'b0;
    cycle();
    start = 1'b1;
    drive(1'b1, 32'h200, 32'h12345013, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
    cycle();
    idle(1'b0, 1'b1);
    cycle();
    cycle();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(3, 0) != 0), $urandom, $urandom, 1'($urandom),
            ($urandom_range(15, 0) == 0), 4'($urandom), $urandom,
            ($urandom_range(19, 0) == 0), 1'($urandom));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupling instruction queue between the fetch stage and the decode stage.
- Captures each fetched instruction with its pc, pc+4, prediction bit and fetch-trap packet, and presents the oldest entry to decode with a valid/ready handshake.
- Absorbs decode stalls without stalling fetch until full. Flushes all in-flight entries on redirect (mispredict or trap).

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy counter.

Ports:
- clk  input  1  core clock, rising edge.
- start  input  1  asynchronous active-low reset; start=0 clears the queue.
- enq_valid  input  1  fetch presents an entry this cycle.
- enq_ready  output  1  queue accepts an entry; fetch stalls when 0.
- pc_f  input  32  fetched pc.
- pcplus4_f  input  32  fetched pc+4.
- inst_f  input  inst_t  fetched instruction.
- pred_taken_f  input  1  branch predictor direction for this pc.
- trap_req_f  input  trap_req_t  fetch-side trap packet.
- flush  input  1  redirect (mispredict or trap redirflag); kill all entries.
- deq_valid  output  1  head entry valid.
- deq_ready  input  1  decode consumes head this cycle.
- pc_d  output  32  head pc.
- pcplus4_d  output  32  head pc+4.
- inst_d  output  inst_t  head instruction.
- pred_taken_d  output  1  head prediction bit.
- trap_req_d  output  trap_req_t  head trap packet.
- count  output  CNT_W  current occupancy.

Behaviour:
- Storage: circular buffer of DEPTH entries {pc, pcplus4, inst, pred_taken, trap_req}. Head and tail pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is a separate register.
- Reset (start=0, asynchronous): head=0, tail=0, count=0, trap_lock=0. Entry storage need not be cleared.
- Reset output values: deq_valid=0, enq_ready=0, count=0. pc_d, pcplus4_d, inst_d, pred_taken_d and trap_req_d all read 0 while count==0.
- enq_ready = start & !trap_lock & (count != DEPTH).
  - Registered-state only; no combinational path from deq_ready.
  - When full, simultaneous dequeue does not open a slot until the next cycle.
- Enqueue occurs when enq_valid & enq_ready & !flush. It writes the entry at tail and increments tail.
- Dequeue occurs when deq_valid & deq_ready & !flush. It increments head.
- Occupancy update: count += enq - deq. Simultaneous enqueue and dequeue leave count unchanged.
- deq_valid = (count != 0).
- Head outputs are a combinational read of entry[head]. When count==0, all head outputs are forced to 0.
- Latency: an entry enqueued in cycle N is visible at the head no earlier than cycle N+1; there is no bypass.
- Trap lock:
  - When an enqueued entry has trap_req_f.valid=1, trap_lock sets in the same edge.
  - No further enqueues are accepted until flush. Fetch past a faulting pc is meaningless.
  - The trapping entry itself drains normally to decode.
- Flush:
  - On the rising edge with flush=1: head=tail=0, count=0, trap_lock=0.
  - Any enqueue or dequeue in that cycle is discarded.
  - deq_valid=0 in the cycle after flush.
  - flush has priority over every other event.
- Handshake rules: head outputs stay stable while deq_valid=1 and deq_ready=0. Fetch may change inputs freely while enq_ready=0.
- Wrap-around: the pointer after DEPTH-1 is 0. Full means count==DEPTH and head==tail. Empty means count==0 and head==tail.
- Reset asserted mid-operation: the queue empties immediately and asynchronously. After start rises, the queue accepts from the first clock edge.

Test Plan:
- Fill without dequeue: 4 entries pc=0x0,0x4,0x8,0xC with deq_ready=0 -> count=4, enq_ready=0. The 5th enqueue (pc=0x10) is rejected. Head stays pc_d=0x0, pcplus4_d=0x4.
- Streaming: enq_valid=1 and deq_ready=1 continuously from empty, pc=0x100 upward by 4 -> deq_valid rises 1 cycle after the first enqueue. Then one entry per cycle in order, count stays 1, no drops across a pointer wrap (16 entries).
- Flush with simultaneous events: count=3, enq_valid=1, deq_ready=1, flush=1 -> next cycle count=0, deq_valid=0, head outputs 0. The enqueue in the flush cycle is not present.
- Trap lock: enqueue pc=0x2 with trap_req_f.valid=1, cause=CAUSE_INST_MISALIGNED, tval=0x2 -> enq_ready=0 next cycle.
  - The entry reaches decode with trap_req_d.cause=CAUSE_INST_MISALIGNED, tval=0x2.
  - After flush, enq_ready=1.
- Decode stall stability: head pc=0x40 and inst=0x00000013, deq_ready held 0 for 5 cycles while fetch enqueues -> pc_d and inst_d unchanged, count saturates at 4.
- Async reset: assert start=0 mid-stream with count=2, between clock edges -> deq_valid, count and enq_ready drop to 0 immediately. After start=1, the first enqueue appears at the head one cycle later.
